// File: rtl/operand_sequencer_pkg.sv
// Shared types for the operand sequencer.
//   addr_mode_t : how an address field is turned into an operand or a
//                 write destination (immediate, register, memory, indirect).
//   seq_state_t : states of the sequencer control FSM.
//   REG_INDEX_WIDTH : width of a register-file index taken from the low
//                     bits of an address field.
package operand_sequencer_pkg;

  localparam int REG_INDEX_WIDTH = 3;

  typedef enum logic [1:0] {
    IMM = 2'd0,
    REG = 2'd1,
    MEM = 2'd2,
    IND = 2'd3
  } addr_mode_t;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    OP_DEC     = 3'd1,
    RF_WAIT    = 3'd2,
    MEM_RD     = 3'd3,
    EXEC       = 3'd4,
    WB_DEC     = 3'd5,
    WB_RF_WAIT = 3'd6,
    MEM_WR     = 3'd7
  } seq_state_t;

endpackage

// File: rtl/operand_sequencer.sv
// Operand sequencer: accepts one parsed instruction at a time, fetches its
// two operands through a shared register-file read port and a shared
// data-memory port, runs the ALU, then writes the result back according to
// the output addressing mode.
//
// Ports:
//   clock, reset_n           : rising-edge clock, asynchronous active-low reset
//   instr_valid/instr_ready  : instruction intake handshake
//   op_code, address*_in, address_out, *_type : parsed instruction fields
//   rf_rd_*                  : register read port (data one cycle after strobe)
//   rf_wr_*                  : register write port
//   mem_*                    : data memory port, mem_ack completes a request
//   alu_*                    : ALU issue/response
//
// Every output is decoded from registered state and registered data, so no
// input reaches an output combinationally.
module operand_sequencer
  import operand_sequencer_pkg::*;
#(
  parameter int OPCODE_WIDTH = 6,
  parameter int VALUE_WIDTH  = 8,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       instr_valid,
  output logic                       instr_ready,
  input  logic [OPCODE_WIDTH-1:0]    op_code,
  input  logic [ADDR_WIDTH-1:0]      address1_in,
  input  logic [ADDR_WIDTH-1:0]      address2_in,
  input  logic [ADDR_WIDTH-1:0]      address_out,
  input  logic [1:0]                 address1_type,
  input  logic [1:0]                 address2_type,
  input  logic [1:0]                 out_type,
  output logic                       rf_rd_en,
  output logic [REG_INDEX_WIDTH-1:0] rf_rd_addr,
  input  logic [VALUE_WIDTH-1:0]     rf_rd_data,
  output logic                       rf_wr_en,
  output logic [REG_INDEX_WIDTH-1:0] rf_wr_addr,
  output logic [VALUE_WIDTH-1:0]     rf_wr_data,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [ADDR_WIDTH-1:0]      mem_addr,
  output logic [VALUE_WIDTH-1:0]     mem_wdata,
  input  logic [VALUE_WIDTH-1:0]     mem_rdata,
  input  logic                       mem_ack,
  output logic                       alu_valid,
  output logic [OPCODE_WIDTH-1:0]    alu_op,
  output logic [VALUE_WIDTH-1:0]     alu_a,
  output logic [VALUE_WIDTH-1:0]     alu_b,
  input  logic                       alu_done,
  input  logic [VALUE_WIDTH-1:0]     alu_result
);

  seq_state_t state_q, state_d;
  logic       sel_q, sel_d;

  logic [OPCODE_WIDTH-1:0] opcode_q;
  logic [ADDR_WIDTH-1:0]   addr1_q, addr2_q, addrout_q;
  addr_mode_t              type1_q, type2_q, typeout_q;

  logic [VALUE_WIDTH-1:0]  opa_q, opa_d;
  logic [VALUE_WIDTH-1:0]  opb_q, opb_d;
  logic [VALUE_WIDTH-1:0]  result_q, result_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;

  logic                    accept;
  logic                    operand_load;
  logic [VALUE_WIDTH-1:0]  operand_val;

  // Both operands share one fetch path; sel picks which field/mode is
  // currently being resolved.
  addr_mode_t            cur_type;
  logic [ADDR_WIDTH-1:0] cur_field;

  assign cur_type  = sel_q ? type2_q : type1_q;
  assign cur_field = sel_q ? addr2_q : addr1_q;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: instruction fields latch on acceptance, the rest
  // follow the next-value logic computed alongside the state transition.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sel_q      <= 1'b0;
      opcode_q   <= '0;
      addr1_q    <= '0;
      addr2_q    <= '0;
      addrout_q  <= '0;
      type1_q    <= IMM;
      type2_q    <= IMM;
      typeout_q  <= IMM;
      opa_q      <= '0;
      opb_q      <= '0;
      result_q   <= '0;
      mem_addr_q <= '0;
    end else begin
      sel_q      <= sel_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      result_q   <= result_d;
      mem_addr_q <= mem_addr_d;
      if (accept) begin
        opcode_q  <= op_code;
        addr1_q   <= address1_in;
        addr2_q   <= address2_in;
        addrout_q <= address_out;
        type1_q   <= addr_mode_t'(address1_type);
        type2_q   <= addr_mode_t'(address2_type);
        typeout_q <= addr_mode_t'(out_type);
      end
    end
  end

  // Next-state and next-data logic. A resolved operand is funnelled
  // through operand_load so the "advance" step is written once: the first
  // operand loops back to OP_DEC with sel=1, the second moves on to EXEC.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    result_d     = result_q;
    mem_addr_d   = mem_addr_q;
    accept       = 1'b0;
    operand_load = 1'b0;
    operand_val  = '0;

    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          accept  = 1'b1;
          sel_d   = 1'b0;
          state_d = OP_DEC;
        end
      end
      OP_DEC: begin
        case (cur_type)
          IMM: begin
            operand_load = 1'b1;
            operand_val  = VALUE_WIDTH'(cur_field);
          end
          REG, IND: state_d = RF_WAIT;
          MEM: begin
            mem_addr_d = cur_field;
            state_d    = MEM_RD;
          end
          default: state_d = IDLE;
        endcase
      end
      RF_WAIT: begin
        // Indirect mode uses the register contents as the memory address.
        if (cur_type == IND) begin
          mem_addr_d = ADDR_WIDTH'(rf_rd_data);
          state_d    = MEM_RD;
        end else begin
          operand_load = 1'b1;
          operand_val  = rf_rd_data;
        end
      end
      MEM_RD: begin
        if (mem_ack) begin
          operand_load = 1'b1;
          operand_val  = mem_rdata;
        end
      end
      EXEC: begin
        if (alu_done) begin
          result_d = alu_result;
          state_d  = WB_DEC;
        end
      end
      WB_DEC: begin
        // Register writes happen in this state; an immediate destination
        // is meaningless and simply drops the result.
        case (typeout_q)
          REG: state_d = IDLE;
          MEM: begin
            mem_addr_d = addrout_q;
            state_d    = MEM_WR;
          end
          IND: state_d = WB_RF_WAIT;
          default: state_d = IDLE;
        endcase
      end
      WB_RF_WAIT: begin
        mem_addr_d = ADDR_WIDTH'(rf_rd_data);
        state_d    = MEM_WR;
      end
      MEM_WR: begin
        if (mem_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (operand_load) begin
      if (!sel_q) begin
        opa_d   = operand_val;
        sel_d   = 1'b1;
        state_d = OP_DEC;
      end else begin
        opb_d   = operand_val;
        state_d = EXEC;
      end
    end
  end

  // Output decode from registered state and data only.
  assign instr_ready = (state_q == IDLE);

  assign rf_rd_en   = ((state_q == OP_DEC) && ((cur_type == REG) || (cur_type == IND)))
                   || ((state_q == WB_DEC) && (typeout_q == IND));
  assign rf_rd_addr = (state_q == WB_DEC) ? addrout_q[REG_INDEX_WIDTH-1:0]
                                          : cur_field[REG_INDEX_WIDTH-1:0];

  assign rf_wr_en   = (state_q == WB_DEC) && (typeout_q == REG);
  assign rf_wr_addr = addrout_q[REG_INDEX_WIDTH-1:0];
  assign rf_wr_data = result_q;

  assign mem_req   = (state_q == MEM_RD) || (state_q == MEM_WR);
  assign mem_we    = (state_q == MEM_WR);
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = result_q;

  assign alu_valid = (state_q == EXEC);
  assign alu_op    = opcode_q;
  assign alu_a     = opa_q;
  assign alu_b     = opb_q;

endmodule

// File: tb/tb_operand_sequencer.sv
// Self-checking bench for operand_sequencer. A single environment process
// models the register file, the data memory (configurable wait states) and
// an adding ALU, and scoreboards every write the DUT performs against
// expectations queued when each instruction is issued. Scenario tasks check
// timing and operand values inline.
module tb_operand_sequencer;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       instr_valid;
  logic       instr_ready;
  logic [5:0] op_code;
  logic [7:0] address1_in, address2_in, address_out;
  logic [1:0] address1_type, address2_type, out_type;
  logic       rf_rd_en;
  logic [2:0] rf_rd_addr;
  logic [7:0] rf_rd_data;
  logic       rf_wr_en;
  logic [2:0] rf_wr_addr;
  logic [7:0] rf_wr_data;
  logic       mem_req, mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_ack;
  logic       alu_valid;
  logic [5:0] alu_op;
  logic [7:0] alu_a, alu_b;
  logic       alu_done;
  logic [7:0] alu_result;

  int checks   = 0;
  int failures = 0;

  logic [7:0] rfModel  [8];
  logic [7:0] memModel [256];
  int         memWait  = 0;
  bit         spurious = 1'b0;

  typedef struct packed {
    logic       isMem;
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t expQ[$];

  always #5 clock = ~clock;

  operand_sequencer #(
    .OPCODE_WIDTH(6),
    .VALUE_WIDTH (8),
    .ADDR_WIDTH  (8)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .op_code      (op_code),
    .address1_in  (address1_in),
    .address2_in  (address2_in),
    .address_out  (address_out),
    .address1_type(address1_type),
    .address2_type(address2_type),
    .out_type     (out_type),
    .rf_rd_en     (rf_rd_en),
    .rf_rd_addr   (rf_rd_addr),
    .rf_rd_data   (rf_rd_data),
    .rf_wr_en     (rf_wr_en),
    .rf_wr_addr   (rf_wr_addr),
    .rf_wr_data   (rf_wr_data),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack),
    .alu_valid    (alu_valid),
    .alu_op       (alu_op),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_done     (alu_done),
    .alu_result   (alu_result)
  );

  // Environment: register file, memory and ALU responders plus the write
  // scoreboard, all in one process so their ordering at each falling edge
  // is fixed.
  initial begin : env
    int   waitCnt;
    bit   rdPend;
    logic [2:0] rdAddr;
    bit   haveWrite;
    wr_t  got;
    wr_t  exp;
    waitCnt = 0;
    rdPend  = 1'b0;
    rdAddr  = '0;
    forever begin
      @(negedge clock);
      haveWrite  = 1'b0;
      got        = '0;
      rf_rd_data = rdPend ? rfModel[rdAddr] : 8'h00;
      rdPend     = reset_n && rf_rd_en;
      rdAddr     = rf_rd_addr;
      mem_ack    = 1'b0;
      alu_done   = 1'b0;
      if (!reset_n) begin
        waitCnt = 0;
      end else if (mem_req) begin
        if (waitCnt >= memWait) begin
          mem_ack = 1'b1;
          waitCnt = 0;
          if (mem_we) begin
            haveWrite = 1'b1;
            got       = '{1'b1, mem_addr, mem_wdata};
          end else begin
            mem_rdata = memModel[mem_addr];
          end
        end else begin
          waitCnt++;
        end
      end else begin
        waitCnt = 0;
        if (spurious) mem_ack = 1'b1;
      end
      if (reset_n && alu_valid) begin
        alu_done   = 1'b1;
        alu_result = alu_a + alu_b;
      end else if (spurious) begin
        alu_done   = 1'b1;
        alu_result = 8'hEE;
      end
      if (reset_n && rf_wr_en) begin
        haveWrite = 1'b1;
        got       = '{1'b0, 8'(rf_wr_addr), rf_wr_data};
      end
      if (haveWrite) begin
        checks++;
        if (expQ.size() == 0) begin
          failures++;
          $display("[TB] FAIL write_unexpected got isMem=%0d addr=%h data=%h required no write",
                   got.isMem, got.addr, got.data);
        end else begin
          exp = expQ.pop_front();
          if (got !== exp) begin
            failures++;
            $display("[TB] FAIL write_scoreboard got isMem=%0d addr=%h data=%h required isMem=%0d addr=%h data=%h",
                     got.isMem, got.addr, got.data, exp.isMem, exp.addr, exp.data);
          end
        end
      end
    end
  end

  // Presents an instruction and returns #1 after the edge that accepts it.
  task automatic applyStimulus(input logic [5:0] op, input logic [7:0] a1, input logic [7:0] a2,
                               input logic [7:0] ao, input logic [1:0] t1, input logic [1:0] t2,
                               input logic [1:0] to, output bit ok);
    @(negedge clock);
    op_code       = op;
    address1_in   = a1;
    address2_in   = a2;
    address_out   = ao;
    address1_type = t1;
    address2_type = t2;
    out_type      = to;
    instr_valid   = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (instr_ready) ok = 1'b1;
      else @(negedge clock);
    end
    if (ok) begin
      @(posedge clock);
      #1;
    end
    instr_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if (instr_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL reset_ready got %b required 1", instr_ready);
    end
    checks++;
    if ({rf_rd_en, rf_wr_en, mem_req, mem_we, alu_valid} !== 5'b0) begin
      failures++; $display("[TB] FAIL reset_strobes got %b required 00000",
                           {rf_rd_en, rf_wr_en, mem_req, mem_we, alu_valid});
    end
    checks++;
    if ({mem_addr, mem_wdata, rf_wr_data, alu_a, alu_b} !== 40'h0) begin
      failures++; $display("[TB] FAIL reset_data got %h required 0",
                           {mem_addr, mem_wdata, rf_wr_data, alu_a, alu_b});
    end
    reset_n = 1'b1;
    @(negedge clock);
    checks++;
    if (instr_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL post_reset_ready got %b required 1", instr_ready);
    end
  endtask

  task automatic test_reset_mid_memrd();
    bit ok;
    bit sawReq;
    bit badStrobe;
    memWait = 20;
    memModel[8'h40] = 8'h55;
    applyStimulus(6'h01, 8'h40, 8'h01, 8'h02, 2'd2, 2'd0, 2'd1, ok);
    checks++;
    if (!ok) begin failures++; $display("[TB] FAIL rst_accept got timeout required accept"); end
    sawReq = 1'b0;
    for (int i = 0; i < 10 && !sawReq; i++) begin
      @(negedge clock);
      if (mem_req) sawReq = 1'b1;
    end
    checks++;
    if (!sawReq) begin failures++; $display("[TB] FAIL rst_memreq_seen got 0 required 1"); end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || instr_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL rst_async got mem_req=%b ready=%b required 0/1", mem_req, instr_ready);
    end
    @(negedge clock);
    reset_n = 1'b1;
    badStrobe = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (!instr_ready || rf_wr_en || mem_req) badStrobe = 1'b1;
    end
    checks++;
    if (badStrobe) begin failures++; $display("[TB] FAIL rst_after got activity required idle"); end
    memWait = 0;
  endtask

  task automatic test_imm_imm_reg();
    bit ok;
    bit sawAlu;
    int wrCycle, wrCount, readyCycle;
    expQ.push_back('{1'b0, 8'h02, 8'h08});
    applyStimulus(6'h01, 8'h05, 8'h03, 8'h02, 2'd0, 2'd0, 2'd1, ok);
    checks++;
    if (!ok) begin failures++; $display("[TB] FAIL iir_accept got timeout required accept"); end
    sawAlu = 1'b0; wrCycle = -1; wrCount = 0; readyCycle = -1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clock);
      if (alu_valid && !sawAlu) begin
        sawAlu = 1'b1;
        checks++;
        if (alu_a !== 8'h05 || alu_b !== 8'h03 || alu_op !== 6'h01) begin
          failures++; $display("[TB] FAIL iir_alu got a=%h b=%h op=%h required 05/03/01", alu_a, alu_b, alu_op);
        end
      end
      if (rf_wr_en) begin
        wrCount++;
        if (wrCycle < 0) wrCycle = k;
      end
      if (instr_ready) begin readyCycle = k; break; end
    end
    checks++;
    if (wrCycle !== 4 || wrCount !== 1) begin
      failures++; $display("[TB] FAIL iir_wr_timing got cycle=%0d count=%0d required 4/1", wrCycle, wrCount);
    end
    checks++;
    if (readyCycle !== 5) begin
      failures++; $display("[TB] FAIL iir_ready_timing got %0d required 5", readyCycle);
    end
  endtask

  task automatic test_reg_mem_mem();
    bit ok;
    bit sawAlu;
    bit badAddr;
    int firstRd, lastRd, rdCycles, readyCycle;
    rfModel[1] = 8'h11;
    memModel[8'h40] = 8'h22;
    memWait = 2;
    expQ.push_back('{1'b1, 8'h80, 8'h33});
    applyStimulus(6'h02, 8'h01, 8'h40, 8'h80, 2'd1, 2'd2, 2'd2, ok);
    checks++;
    if (!ok) begin failures++; $display("[TB] FAIL rmm_accept got timeout required accept"); end
    sawAlu = 1'b0; badAddr = 1'b0; firstRd = -1; lastRd = -1; rdCycles = 0; readyCycle = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (mem_req && !mem_we) begin
        rdCycles++;
        if (firstRd < 0) firstRd = k;
        lastRd = k;
        if (mem_addr !== 8'h40) badAddr = 1'b1;
      end
      if (alu_valid && !sawAlu) begin
        sawAlu = 1'b1;
        checks++;
        if (alu_a !== 8'h11 || alu_b !== 8'h22) begin
          failures++; $display("[TB] FAIL rmm_alu got a=%h b=%h required 11/22", alu_a, alu_b);
        end
      end
      if (instr_ready) begin readyCycle = k; break; end
    end
    checks++;
    if (rdCycles !== 3 || firstRd !== 4 || lastRd !== 6 || badAddr) begin
      failures++; $display("[TB] FAIL rmm_read_hold got cycles=%0d first=%0d last=%0d badAddr=%0d required 3/4/6/0",
                           rdCycles, firstRd, lastRd, badAddr);
    end
    checks++;
    if (readyCycle !== 12) begin
      failures++; $display("[TB] FAIL rmm_ready_timing got %0d required 12", readyCycle);
    end
    memWait = 0;
  endtask

  task automatic test_ind_imm_ind();
    bit ok;
    bit sawAlu;
    int rdCycle, readyCycle;
    logic [7:0] rdAddrSeen;
    rfModel[1] = 8'h20;
    rfModel[3] = 8'h90;
    memModel[8'h20] = 8'h07;
    memWait = 0;
    expQ.push_back('{1'b1, 8'h90, 8'h08});
    applyStimulus(6'h03, 8'h01, 8'h01, 8'h03, 2'd3, 2'd0, 2'd3, ok);
    checks++;
    if (!ok) begin failures++; $display("[TB] FAIL iii_accept got timeout required accept"); end
    sawAlu = 1'b0; rdCycle = -1; readyCycle = -1; rdAddrSeen = 8'h00;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (mem_req && !mem_we && rdCycle < 0) begin
        rdCycle = k;
        rdAddrSeen = mem_addr;
      end
      if (alu_valid && !sawAlu) begin
        sawAlu = 1'b1;
        checks++;
        if (alu_a !== 8'h07 || alu_b !== 8'h01) begin
          failures++; $display("[TB] FAIL iii_alu got a=%h b=%h required 07/01", alu_a, alu_b);
        end
      end
      if (instr_ready) begin readyCycle = k; break; end
    end
    checks++;
    if (rdCycle !== 3 || rdAddrSeen !== 8'h20) begin
      failures++; $display("[TB] FAIL iii_read got cycle=%0d addr=%h required 3/20", rdCycle, rdAddrSeen);
    end
    checks++;
    if (readyCycle !== 9) begin
      failures++; $display("[TB] FAIL iii_ready_timing got %0d required 9", readyCycle);
    end
  endtask

  task automatic test_out_illegal();
    bit ok;
    bit sawWrite;
    int readyCycle;
    applyStimulus(6'h04, 8'h02, 8'h02, 8'h00, 2'd0, 2'd0, 2'd0, ok);
    checks++;
    if (!ok) begin failures++; $display("[TB] FAIL ill_accept got timeout required accept"); end
    sawWrite = 1'b0; readyCycle = -1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clock);
      if (rf_wr_en || mem_req) sawWrite = 1'b1;
      if (instr_ready) begin readyCycle = k; break; end
    end
    checks++;
    if (sawWrite || readyCycle !== 5) begin
      failures++; $display("[TB] FAIL ill_no_write got write=%0d ready=%0d required 0/5", sawWrite, readyCycle);
    end
  endtask

  task automatic test_back_to_back();
    logic [12:0] readyMask;
    logic [12:0] expMask;
    int wrCount;
    bit idleBad;
    expMask = 13'b1_1100_0010_0001;
    expQ.push_back('{1'b0, 8'h05, 8'h0C});
    expQ.push_back('{1'b0, 8'h05, 8'h0C});
    @(negedge clock);
    op_code = 6'h05; address1_in = 8'h07; address2_in = 8'h05; address_out = 8'h05;
    address1_type = 2'd0; address2_type = 2'd0; out_type = 2'd1;
    instr_valid = 1'b1;
    readyMask = '0; wrCount = 0;
    for (int k = 0; k <= 12; k++) begin
      if (k > 0) @(negedge clock);
      if (k == 6) instr_valid = 1'b0;
      readyMask[k] = instr_ready;
      if (rf_wr_en) wrCount++;
    end
    checks++;
    if (readyMask !== expMask) begin
      failures++; $display("[TB] FAIL b2b_ready_pattern got %b required %b", readyMask, expMask);
    end
    checks++;
    if (wrCount !== 2) begin
      failures++; $display("[TB] FAIL b2b_write_count got %0d required 2", wrCount);
    end
    spurious = 1'b1;
    idleBad = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      if (!instr_ready || alu_valid || mem_req || rf_rd_en) idleBad = 1'b1;
    end
    spurious = 1'b0;
    @(negedge clock);
    if (!instr_ready || alu_valid || mem_req) idleBad = 1'b1;
    checks++;
    if (idleBad) begin
      failures++; $display("[TB] FAIL spurious_idle got state change required idle");
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    instr_valid = 1'b0;
    op_code = '0; address1_in = '0; address2_in = '0; address_out = '0;
    address1_type = '0; address2_type = '0; out_type = '0;
    rf_rd_data = '0; mem_rdata = '0; mem_ack = 1'b0; alu_done = 1'b0; alu_result = '0;
    for (int i = 0; i < 8; i++) rfModel[i] = 8'h00;
    for (int i = 0; i < 256; i++) memModel[i] = 8'h00;

    test_reset();
    test_reset_mid_memrd();
    test_imm_imm_reg();
    test_reg_mem_mem();
    test_ind_imm_ind();
    test_out_illegal();
    test_back_to_back();

    repeat (3) @(negedge clock);
    checks++;
    if (expQ.size() != 0) begin
      failures++; $display("[TB] FAIL scoreboard_drain got %0d pending required 0", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
